// File: rtl/conv1d_requant.sv
// conv1d_requant: TFLite per-layer requantization of int32 accumulators to int8, 4-stage valid/ready pipeline.
// Optional macro REQUANT_PACK4_EN packs four results into each 32-bit output word.
module conv1d_requant #(
  parameter int INT32_SIZE = 32,
  parameter int BYTE_SIZE  = 8,
`ifdef REQUANT_PACK4_EN
  localparam int OUT_W = 4 * BYTE_SIZE
`else
  localparam int OUT_W = BYTE_SIZE
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_addr,
  input  logic [INT32_SIZE-1:0] cfg_data,
  output logic                  cfg_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INT32_SIZE-1:0] in_acc,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data
);

  localparam int PW = 2 * INT32_SIZE;

  logic signed [INT32_SIZE-1:0] mult_r, shift_r, offset_r, act_min_r, act_max_r;
  logic                         v1_r, v2_r, v3_r;
  logic                         last1_r, last2_r, last3_r;
  logic signed [INT32_SIZE-1:0] x1_r, r3_r;
  logic signed [PW-1:0]         ab2_r;
  logic                         sat2_r;
  logic                         advance_s, cfg_ok_s;
  logic [INT32_SIZE-1:0]        ls_s;
  logic [4:0]                   rs_s;
  logic signed [BYTE_SIZE-1:0]  res_s;

  // Rounding doubling high-half multiply; the only overflow case is forced to INT32_MAX.
  function automatic logic signed [INT32_SIZE-1:0] high_mul(
    input logic signed [PW-1:0] ab,
    input logic                 sat
  );
    logic signed [PW-1:0] s;
    logic signed [PW-1:0] q;
    s = ab + ((ab >= 64'sd0) ? 64'sd1073741824 : -64'sd1073741823);
    q = s >>> 31;
    if (s < 64'sd0 && s[30:0] != 31'd0) q = q + 64'sd1;
    else                                q = q;
    return sat ? 32'sh7fffffff : q[INT32_SIZE-1:0];
  endfunction

  function automatic logic signed [INT32_SIZE-1:0] round_div(
    input logic signed [INT32_SIZE-1:0] h,
    input logic [4:0]                   rs
  );
    logic [INT32_SIZE-1:0] mask, rem, thr;
    mask = (32'd1 << rs) - 32'd1;
    rem  = h & mask;
    thr  = (mask >> 1) + {31'd0, h[INT32_SIZE-1]};
    return (h >>> rs) + ((rem > thr) ? 32'sd1 : 32'sd0);
  endfunction

  // min is applied before max, so an inverted window resolves to max.
  function automatic logic signed [BYTE_SIZE-1:0] act_clamp(
    input logic signed [INT32_SIZE-1:0] r, off, lo, hi
  );
    logic signed [INT32_SIZE-1:0] y;
    y = r + off;
    if (y < lo) y = lo;
    else        y = y;
    if (y > hi) y = hi;
    else        y = y;
    if (y > 32'sd127)       y = 32'sd127;
    else if (y < -32'sd128) y = -32'sd128;
    else                    y = y;
    return y[BYTE_SIZE-1:0];
  endfunction

  assign advance_s = !out_valid || out_ready;
  assign in_ready  = advance_s;
  assign cfg_ok_s  = !(v1_r || v2_r || v3_r || out_valid || in_valid);
  assign res_s     = act_clamp(r3_r, offset_r, act_min_r, act_max_r);

  // Split the signed shift into a left amount and a right amount saturated to 31.
  always_comb begin
    ls_s = '0;
    rs_s = 5'd0;
    if (shift_r > 32'sd0) begin
      ls_s = shift_r;
      rs_s = 5'd0;
    end else if (shift_r < -32'sd31) begin
      ls_s = '0;
      rs_s = 5'd31;
    end else begin
      ls_s = '0;
      rs_s = 5'(-shift_r);
    end
  end

  // Config registers and the reject pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mult_r    <= 32'sh40000000;
      shift_r   <= 32'sd1;
      offset_r  <= 32'sd0;
      act_min_r <= -32'sd128;
      act_max_r <= 32'sd127;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok_s;
      if (cfg_we && cfg_ok_s) begin
        case (cfg_addr)
          3'd0:    mult_r    <= cfg_data;
          3'd1:    shift_r   <= cfg_data;
          3'd2:    offset_r  <= cfg_data;
          3'd3:    act_min_r <= cfg_data;
          3'd4:    act_max_r <= cfg_data;
          default: ;
        endcase
      end
    end
  end

  // Stages 1-3: shift, multiply, round; all advance together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_r    <= 1'b0;
      v2_r    <= 1'b0;
      v3_r    <= 1'b0;
      last1_r <= 1'b0;
      last2_r <= 1'b0;
      last3_r <= 1'b0;
      x1_r    <= '0;
      ab2_r   <= '0;
      sat2_r  <= 1'b0;
      r3_r    <= '0;
    end else if (advance_s) begin
      v1_r    <= in_valid;
      last1_r <= in_last;
      x1_r    <= in_acc << ls_s;
      v2_r    <= v1_r;
      last2_r <= last1_r;
      ab2_r   <= {{INT32_SIZE{x1_r[INT32_SIZE-1]}}, x1_r} * {{INT32_SIZE{mult_r[INT32_SIZE-1]}}, mult_r};
      sat2_r  <= (x1_r == 32'h80000000) && (mult_r == 32'h80000000);
      v3_r    <= v2_r;
      last3_r <= last2_r;
      r3_r    <= round_div(high_mul(ab2_r, sat2_r), rs_s);
    end
  end

`ifdef REQUANT_PACK4_EN
  logic [OUT_W-1:0] base_word_s, word_s;
  logic [1:0]       lane_r, base_lane_s;

  // A word being handed off this cycle restarts packing at lane 0.
  always_comb begin
    base_word_s = out_valid ? '0 : out_data;
    base_lane_s = out_valid ? 2'd0 : lane_r;
    word_s      = base_word_s;
    case (base_lane_s)
      2'd0:    word_s[7:0]   = res_s;
      2'd1:    word_s[15:8]  = res_s;
      2'd2:    word_s[23:16] = res_s;
      2'd3:    word_s[31:24] = res_s;
      default: word_s        = base_word_s;
    endcase
  end

  // Stage 4: packer, closes a word on the fourth lane or on a row end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      lane_r    <= 2'd0;
    end else if (advance_s) begin
      if (v3_r) begin
        out_data <= word_s;
        if (base_lane_s == 2'd3 || last3_r) begin
          out_valid <= 1'b1;
          lane_r    <= 2'd0;
        end else begin
          out_valid <= 1'b0;
          lane_r    <= base_lane_s + 2'd1;
        end
      end else begin
        out_valid <= 1'b0;
        out_data  <= base_word_s;
        lane_r    <= base_lane_s;
      end
    end
  end
`else
  logic unused_last_s;
  assign unused_last_s = last3_r;

  // Stage 4: offset, clamp and output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (advance_s) begin
      out_valid <= v3_r;
      if (v3_r) out_data <= res_s;
    end
  end
`endif

endmodule

// File: tb/tb_conv1d_requant.sv
// Directed self-checking bench for conv1d_requant (default build, or REQUANT_PACK4_EN when defined).
module tb_conv1d_requant;
`ifdef REQUANT_PACK4_EN
  localparam int OUT_W = 32;
`else
  localparam int OUT_W = 8;
`endif

  logic             clk = 1'b0;
  logic             reset, cfg_we, cfg_err, in_valid, in_ready, in_last, out_valid, out_ready;
  logic [2:0]       cfg_addr;
  logic [31:0]      cfg_data, in_acc;
  logic [OUT_W-1:0] out_data;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int got_q[$];
  int got_edge_q[$];
  int acc_q[$];

  conv1d_requant dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every output transfer together with the edge it completes on.
  always @(negedge clk) begin
    #3;
    if (!reset && out_valid && out_ready) begin
`ifdef REQUANT_PACK4_EN
      got_q.push_back(int'(out_data));
`else
      got_q.push_back(int'($signed(out_data)));
`endif
      got_edge_q.push_back(cyc + 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d checks", n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int got(input int i);
    if (i < got_q.size()) return got_q[i];
    else                  return -999999;
  endfunction

  function automatic int lat(input int i);
    if (i < got_edge_q.size() && i < acc_q.size()) return got_edge_q[i] - acc_q[i];
    else                                           return -1;
  endfunction

  task automatic clear();
    got_q.delete();
    got_edge_q.delete();
    acc_q.delete();
  endtask

  // Called at a falling edge; returns at the falling edge after the accept, in_valid still high.
  task automatic push(input int acc, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_acc   = acc;
    in_last  = last;
    #1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!in_ready) check("push_timeout", int'(in_ready), 1);
    else           acc_q.push_back(cyc + 1);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] addr, input int data, input logic exp_err, input string tag);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
    check(tag, int'(cfg_err), int'(exp_err));
  endtask

  // Wait for n results, then a few more cycles to catch duplicates.
  task automatic wait_results(input int n, input string tag);
    int t = 0;
    while (got_q.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    check(tag, got_q.size(), n);
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 32'd0;
    in_valid = 1'b0; in_acc = 32'd0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_in_ready", int'(in_ready), 1);
    reset = 1'b0;
    @(negedge clk);

`ifdef REQUANT_PACK4_EN
    clear();
    for (int i = 1; i <= 7; i++) push(i, (i == 3) ? 1'b1 : 1'b0);
    idle();
    wait_results(2, "pack_count");
    check("pack_word0", got(0), 32'h00030201);
    check("pack_word1", got(1), 32'h07060504);

    clear();
    push(200, 1'b0);
    push(-300, 1'b1);
    idle();
    wait_results(1, "pack_clamp_count");
    check("pack_clamp", got(0), 32'h0000807F);

    cfg_write(3'd1, 1, 1'b0, "pack_cfg_ok");
    clear();
    for (int i = 8; i <= 11; i++) push(i, 1'b0);
    idle();
    wait_results(1, "pack_full_count");
    check("pack_full", got(0), 32'h0B0A0908);
`else
    // Default identity scale, including both clamp rails and the 4-edge latency.
    clear();
    push(100, 1'b0);
    push(-300, 1'b0);
    push(200, 1'b0);
    idle();
    wait_results(3, "def_count");
    check("def_100", got(0), 100);
    check("def_m300", got(1), -128);
    check("def_200", got(2), 127);
    for (int i = 0; i < 3; i++) check("def_latency", lat(i), 4);

    cfg_write(3'd1, 0, 1'b0, "cfg_shift0");
    clear();
    push(5, 1'b0);
    push(-5, 1'b0);
    idle();
    wait_results(2, "round_count");
    check("round_p5", got(0), 3);
    check("round_m5", got(1), -2);

    cfg_write(3'd0, 32'h80000000, 1'b0, "cfg_mult_min");
    clear();
    push(32'h80000000, 1'b0);
    idle();
    wait_results(1, "sat_count");
    check("sat_path", got(0), 127);

    cfg_write(3'd0, 32'h40000000, 1'b0, "cfg_mult_half");
    cfg_write(3'd1, -1, 1'b0, "cfg_shift_m1");
    cfg_write(3'd2, -10, 1'b0, "cfg_offset_m10");
    clear();
    push(5, 1'b0);
    idle();
    wait_results(1, "rshift_count");
    check("rshift_offset", got(0), -8);

    cfg_write(3'd1, 1, 1'b0, "cfg_shift1");
    cfg_write(3'd2, 0, 1'b0, "cfg_offset0");
    cfg_write(3'd3, 50, 1'b0, "cfg_min50");
    cfg_write(3'd4, 20, 1'b0, "cfg_max20");
    clear();
    push(0, 1'b0);
    idle();
    wait_results(1, "inv_count");
    check("inverted_window", got(0), 20);
    cfg_write(3'd3, -128, 1'b0, "cfg_min_def");
    cfg_write(3'd4, 127, 1'b0, "cfg_max_def");

    // Backpressure: six inputs against a stalled consumer for ten cycles.
    clear();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) push(10 * (i + 1), 1'b0);
        idle();
      end
      begin
        repeat (8) @(negedge clk);
        #2;
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_accepts", acc_q.size(), 4);
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_results(6, "bp_count");
    for (int i = 0; i < 6; i++) check("bp_order", got(i), 10 * (i + 1));

    // Rejected config write while busy: old config stays in force.
    clear();
    push(7, 1'b0);
    push(9, 1'b0);
    idle();
    cfg_write(3'd2, 50, 1'b1, "busy_cfg_err");
    wait_results(2, "busy_count");
    check("busy_old_7", got(0), 7);
    check("busy_old_9", got(1), 9);
    clear();
    push(11, 1'b0);
    idle();
    wait_results(1, "busy_after_count");
    check("busy_after", got(0), 11);

    // Reset with three entries in flight, non-default offset configured.
    cfg_write(3'd2, 20, 1'b0, "cfg_offset20");
    clear();
    push(1, 1'b0);
    push(2, 1'b0);
    push(3, 1'b0);
    idle();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_async_out_valid", int'(out_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    clear();
    repeat (8) @(negedge clk);
    check("rst_no_output", got_q.size(), 0);
    push(100, 1'b0);
    idle();
    wait_results(1, "rst_after_count");
    check("rst_default_cfg", got(0), 100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/conv1d_requant.md
Name: conv1d_requant

Overview:
- Downstream stage of the conv1d CFU.
- Consumes the raw int32 accumulators (bias already added) that conv1d produces per output position, one per handshake.
- Applies the TFLite per-layer requantization: quantized multiplier, power-of-two shift, output offset, activation clamp.
- Emits int8 results on a valid/ready stream, through a 4-stage pipeline with backpressure.

Parameters:
- INT32_SIZE, 32, accumulator and config word width.
- BYTE_SIZE, 8, output element width.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- cfg_we  input  1  config write strobe
- cfg_addr  input  3  0=output_multiplier, 1=output_shift, 2=output_offset, 3=output_activation_min, 4=output_activation_max; 5-7 ignored
- cfg_data  input  32  config value (signed)
- cfg_err  output  1  one-cycle pulse: config write rejected
- in_valid  input  1  accumulator valid
- in_ready  output  1  stage can accept
- in_acc  input  32  signed accumulator
- in_last  input  1  last element of row (used by the pack feature only)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts
- out_data  output  8 (32 with pack feature)  signed result

Behaviour:
- Reset values:
  - Outputs: out_valid=0, out_data=0, cfg_err=0; all stage valids cleared.
  - Config: multiplier=0x40000000, shift=1 (identity scale), offset=0, min=-128, max=127.
- Pipeline advance: advance = !out_valid || out_ready. in_ready = advance, combinational. Transfer on in_valid && in_ready. All stages move together; bubbles are not collapsed.
- Capacity is 4 entries. Latency is 4: an accept at edge N gives out_valid at edge N+4 if never stalled. out_data is held stable while out_valid && !out_ready.
- Shift split: ls = shift>0 ? shift : 0; rs = shift>0 ? 0 : -shift. rs is limited to 0..31; larger values saturate to 31.
- S1: x = in_acc << ls, 32-bit wrap.
- S2: ab = x * multiplier, signed 64-bit. Flag sat = (x == multiplier == 0x80000000).
- S3 (rounding high-half multiply):
  - nudge = ab>=0 ? 2^30 : 1-2^30.
  - h = (ab+nudge)/2^31, truncated toward zero.
  - If sat, h = 0x7FFFFFFF.
- S3 (rounding divide by 2^rs):
  - mask = 2^rs-1; rem = h & mask; thr = (mask>>1) + (h<0).
  - r = (h>>>rs) + (rem>thr).
- S4: y = r + offset, 32-bit. Clamp to [min, max], then clamp to the int8 range. Register the result into out_data.
- Config writes:
  - Accepted only when no stage is valid and in_valid=0.
  - Otherwise the write is dropped and cfg_err pulses for one cycle.
  - An accepted write takes effect from the next cycle.
  - min>max is not checked; the result is max after the sequential clamp.
- Reset asserted mid-stream: all in-flight entries are discarded and config returns to defaults. out_valid falls asynchronously.
- Simultaneous in and out transfer on the same edge: allowed, full throughput of 1 per cycle.

Optional Feature:
- Macro: REQUANT_PACK4_EN.
- When defined:
  - out_data is 32 bits: four consecutive results, little-endian, first result in bits 7:0.
  - out_valid asserts once 4 results are packed, or when an element carrying in_last reaches the packer; unused lanes are zero.
  - The packer holds one word. The pipeline stalls while a full word waits for out_ready.
- When undefined:
  - out_data is 8 bits, one result per transfer, and in_last is ignored.

Test Plan:
- Default config, in_acc = 100, -300, 200 -> out_data = 100, -128, 127, in order, each 4 cycles after accept.
- multiplier=0x40000000, shift=0, in_acc=5 -> 3; in_acc=-5 -> -2 (TFLite rounding asymmetry).
- multiplier=0x80000000, shift=0, in_acc=0x80000000 -> saturation path gives 0x7FFFFFFF -> out_data=127, not -128.
- multiplier=0x40000000, shift=-1, offset=-10, in_acc=5 -> r=2 -> out_data=-8.
- Backpressure:
  - Setup: feed 6 accumulators continuously with out_ready=0 for 10 cycles, then out_ready=1.
  - Stall: in_ready drops after 4 accepts.
  - Release: all 6 results are delivered in order, none lost or duplicated.
- Config write with 2 entries in flight -> cfg_err pulses, results use the old config.
- Reset mid-stream: reset high for 1 cycle with 3 entries in flight -> no out_valid afterwards, and the next input produces a result under default config.
- Pack feature (REQUANT_PACK4_EN): inputs 1,2,3 (third with in_last), then 4..7:
  - First word 0x00030201.
  - Second word 0x07060504.
